score_ctrl: RTL and testbench
=============================

// Module: score_ctrl
// PURPOSE
//  Pong match sequencer upstream of the two score-digit renderers. Turns raw
//  miss_l/miss_r events from the ball logic into one-cycle increment pulses
//  for the digit counters. Drives a clear pulse at match start.
//  Times the serve delay in frames and detects the winning score.
// PARAMETERS
//  WIN_SCORE      9    points that end the match (1..9, one decimal digit)
//  SERVE_FRAMES   60   frame pulses waited in SERVE before launching ball (0..255)
//  RESTART_FRAMES 180  frames in GAMEOVER before auto-return (AUTO_RESTART_EN only)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-low reset
//  frame      in   1  one-cycle pulse per video frame (start of vblank)
//  start      in   1  debounced start button, level, active-high
//  miss_l     in   1  level: ball beyond left paddle (point to right player)
//  miss_r     in   1  level: ball beyond right paddle (point to left player)
//  inc_l      out  1  one-cycle pulse: left digit increment
//  inc_r      out  1  one-cycle pulse: right digit increment
//  score_clr  out  1  one-cycle pulse: both digits reset to 0
//  serve      out  1  one-cycle pulse: ball logic relaunches from centre
//  serve_dir  out  1  0 = launch toward left player, 1 = toward right
//  ball_en    out  1  level: ball moving/visible
//  game_over  out  1  level: match finished
//  winner     out  1  valid while game_over: 0 = left, 1 = right
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; internal scores sc_l=sc_r=0; frame cnt 0.
//   start_q/miss_l_q/miss_r_q edge registers reset to 1 (held input = no edge).
//  Edges: X_rise = X & ~X_q, registered each clk. Every output is registered:
//   pulse appears the cycle after the edge where the input was first sampled high.
//  States (2-bit): IDLE, SERVE, PLAY, GAMEOVER.
//  IDLE: ball_en=0. start_rise -> score_clr pulse, sc_l=sc_r=0, serve_dir=0,
//   cnt<=SERVE_FRAMES, -> SERVE.
//  SERVE: ball_en=0. frame & cnt!=0 -> cnt-1. cnt==0 -> serve pulse, -> PLAY.
//   A serve therefore fires one clk after the SERVE_FRAMES-th frame pulse.
//   SERVE_FRAMES=0 fires one clk after entry.
//  PLAY: ball_en=1. miss_l_rise -> inc_r pulse, sc_r+1, serve_dir<=0 (loser).
//   miss_r_rise -> inc_l pulse, sc_l+1, serve_dir<=1.
//   Both rising in the same clk: miss_l wins; only inc_r is issued.
//   After a point: if new score == WIN_SCORE -> GAMEOVER, winner set,
//   game_over=1; else cnt<=SERVE_FRAMES -> SERVE.
//  Misses outside PLAY are ignored. Start outside IDLE/GAMEOVER is ignored.
//  GAMEOVER: ball_en=0, game_over=1, scores held (digits keep displaying).
//   start_rise -> same action as IDLE start; game_over drops with score_clr.
//  At most one of inc_l/inc_r/score_clr/serve is high in any clk.
//  Scores saturate at WIN_SCORE; never wrap. Async reset mid-match returns
//   to IDLE at once with no pulses; the digits must be cleared by the next
//   score_clr.
// CONFIGURATION
//  AUTO_RESTART_EN defined: GAMEOVER loads cnt<=RESTART_FRAMES (8-bit cnt
//   widened to 8 bits max of both params) and decrements per frame. At cnt==0
//   -> IDLE, game_over=0, scores and digits untouched. start_rise while
//   counting restarts immediately.
//  AUTO_RESTART_EN undefined: GAMEOVER is left only by start_rise or rst;
//   RESTART_FRAMES unused.
// TESTING
//  1 rst low then high, start held high -> no score_clr; state IDLE, outputs 0.
//  2 start 0->1 -> score_clr 1 clk; 60 frame pulses -> serve 1 clk later,
//    serve_dir=0, ball_en=1.
//  3 PLAY, miss_r rises and stays high 5 clk -> exactly one inc_l pulse,
//    serve_dir=1; next serve after 60 frames.
//  4 miss_l and miss_r rise same clk -> inc_r only, inc_l stays 0.
//  5 right player reaches 9 -> game_over=1, winner=1, ball_en=0;
//    further misses give no inc.
//  6 AUTO_RESTART_EN: 180 frames after game over -> IDLE, game_over=0;
//    without it, game_over holds until start_rise.

Source files
------------

// File: rtl/score_ctrl.sv
// score_ctrl: Pong match sequencer driving score-digit pulses, serve timing and win detection.
// Optional AUTO_RESTART_EN: GAMEOVER returns to IDLE after RESTART_FRAMES frames.
module score_ctrl #(
   parameter int WIN_SCORE      = 9,
   parameter int SERVE_FRAMES   = 60,
   parameter int RESTART_FRAMES = 180
) (
   input  logic clk,
   input  logic rst,
   input  logic frame,
   input  logic start,
   input  logic miss_l,
   input  logic miss_r,
   output logic inc_l,
   output logic inc_r,
   output logic score_clr,
   output logic serve,
   output logic serve_dir,
   output logic ball_en,
   output logic game_over,
   output logic winner
);
   localparam int CMAX = (RESTART_FRAMES > SERVE_FRAMES) ? RESTART_FRAMES : SERVE_FRAMES;
   localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX + 1);
   typedef enum logic [1:0] {IDLE, SERVE, PLAY, GAMEOVER} state_t;
   state_t state;
   logic [3:0] sc_l, sc_r;
   logic [CW-1:0] cnt;
   logic start_q, miss_l_q, miss_r_q;
   logic start_rise, miss_l_rise, miss_r_rise;
   assign start_rise  = start & ~start_q;
   assign miss_l_rise = miss_l & ~miss_l_q;
   assign miss_r_rise = miss_r & ~miss_r_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         sc_l      <= '0;
         sc_r      <= '0;
         cnt       <= '0;
         start_q   <= 1'b1;
         miss_l_q  <= 1'b1;
         miss_r_q  <= 1'b1;
         inc_l     <= 1'b0;
         inc_r     <= 1'b0;
         score_clr <= 1'b0;
         serve     <= 1'b0;
         serve_dir <= 1'b0;
         ball_en   <= 1'b0;
         game_over <= 1'b0;
         winner    <= 1'b0;
      end else begin
         start_q   <= start;
         miss_l_q  <= miss_l;
         miss_r_q  <= miss_r;
         inc_l     <= 1'b0;
         inc_r     <= 1'b0;
         score_clr <= 1'b0;
         serve     <= 1'b0;
         case (state)
            IDLE, GAMEOVER: begin
               if (start_rise) begin
                  score_clr <= 1'b1;
                  sc_l      <= '0;
                  sc_r      <= '0;
                  serve_dir <= 1'b0;
                  game_over <= 1'b0;
                  winner    <= 1'b0;
                  cnt       <= CW'(SERVE_FRAMES);
                  state     <= SERVE;
               end
`ifdef AUTO_RESTART_EN
               else if (state == GAMEOVER) begin
                  if (cnt == '0) begin
                     game_over <= 1'b0;
                     winner    <= 1'b0;
                     state     <= IDLE;
                  end else if (frame)
                     cnt <= cnt - CW'(1);
               end
`endif
            end
            SERVE: begin
               if (cnt == '0) begin
                  serve   <= 1'b1;
                  ball_en <= 1'b1;
                  state   <= PLAY;
               end else if (frame)
                  cnt <= cnt - CW'(1);
            end
            PLAY: begin
               // miss_l takes priority so only one increment pulse can issue per clk
               if (miss_l_rise || miss_r_rise) begin
                  ball_en <= 1'b0;
                  if (miss_l_rise) begin
                     inc_r     <= 1'b1;
                     serve_dir <= 1'b0;
                     sc_r      <= (sc_r < 4'(WIN_SCORE)) ? sc_r + 4'd1 : sc_r;
                  end else begin
                     inc_l     <= 1'b1;
                     serve_dir <= 1'b1;
                     sc_l      <= (sc_l < 4'(WIN_SCORE)) ? sc_l + 4'd1 : sc_l;
                  end
                  if (miss_l_rise ? (sc_r >= 4'(WIN_SCORE - 1)) : (sc_l >= 4'(WIN_SCORE - 1))) begin
                     game_over <= 1'b1;
                     winner    <= miss_l_rise;
                     cnt       <= CW'(RESTART_FRAMES);
                     state     <= GAMEOVER;
                  end else begin
                     cnt   <= CW'(SERVE_FRAMES);
                     state <= SERVE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: directed vector bench for score_ctrl with default parameters.
module tb_score_ctrl;
   logic clk = 1'b0, rst = 1'b1, frame = 1'b0, start = 1'b1, miss_l = 1'b0, miss_r = 1'b0;
   logic inc_l, inc_r, score_clr, serve, serve_dir, ball_en, game_over, winner;
   logic [7:0] o;
   int checks = 0, failures = 0;
   typedef struct {
      string      name;
      logic [3:0] in;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[6];

   score_ctrl dut (
      .clk(clk), .rst(rst), .frame(frame), .start(start), .miss_l(miss_l), .miss_r(miss_r),
      .inc_l(inc_l), .inc_r(inc_r), .score_clr(score_clr), .serve(serve), .serve_dir(serve_dir),
      .ball_en(ball_en), .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;
   assign o = {inc_l, inc_r, score_clr, serve, serve_dir, ball_en, game_over, winner};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] in);
      {start, frame, miss_l, miss_r} = in;
      tick();
   endtask

   // winner is only meaningful while game_over is expected high
   task automatic check(input string name, input logic [7:0] exp);
      logic [7:0] m;
      m = exp[1] ? 8'hFF : 8'hFE;
      checks++;
      if ((o & m) !== (exp & m)) begin
         failures++;
         $display("FAIL %s: got %b want %b", name, o, exp);
      end
   endtask

   task automatic do_serve(input logic dir, input string name);
      for (int i = 0; i < 59; i++) begin
         drive(4'b0100);
         drive(4'b0000);
      end
      check({name, "_wait"}, {4'b0000, dir, 3'b000});
      drive(4'b0100);
      check({name, "_last_frame"}, {4'b0000, dir, 3'b000});
      drive(4'b0000);
      check({name, "_pulse"}, {4'b0001, dir, 3'b100});
      drive(4'b0000);
      check({name, "_play"}, {4'b0000, dir, 3'b100});
   endtask

   initial begin
      tbl[0] = '{"play_idle",      4'b0000, 8'b0000_0100};
      tbl[1] = '{"play_start_ign", 4'b1000, 8'b0000_0100};
      tbl[2] = '{"play_miss_r",    4'b0001, 8'b1000_1000};
      tbl[3] = '{"srv_miss_l_ign", 4'b0011, 8'b0000_1000};
      tbl[4] = '{"srv_start_ign",  4'b1000, 8'b0000_1000};
      tbl[5] = '{"srv_quiet",      4'b0000, 8'b0000_1000};
      #2 rst = 1'b0;
      repeat (2) tick();
      check("reset", 8'b0);
      rst = 1'b1;
      repeat (3) begin
         drive(4'b1000);
         check("start_held", 8'b0);
      end
      drive(4'b0000);
      check("start_low", 8'b0);
      drive(4'b1000);
      check("score_clr", 8'b0010_0000);
      drive(4'b1000);
      check("clr_one_clk", 8'b0);
      drive(4'b0000);
      do_serve(1'b0, "serve1");
      drive(4'b0001);
      check("inc_l", 8'b1000_1000);
      repeat (4) begin
         drive(4'b0001);
         check("miss_r_held", 8'b0000_1000);
      end
      drive(4'b0000);
      do_serve(1'b1, "serve2");
      drive(4'b0011);
      check("both_miss", 8'b0100_0000);
      drive(4'b0011);
      check("both_held", 8'b0);
      drive(4'b0000);
      do_serve(1'b0, "serve3");
      for (int k = 2; k <= 9; k++) begin
         drive(4'b0010);
         check("right_point", (k == 9) ? 8'b0100_0011 : 8'b0100_0000);
         drive(4'b0000);
         if (k < 9) do_serve(1'b0, "serve_r");
      end
      drive(4'b0010);
      check("go_miss_l", 8'b0000_0011);
      drive(4'b0001);
      check("go_miss_r", 8'b0000_0011);
      drive(4'b0000);
      for (int i = 0; i < 179; i++) begin
         drive(4'b0100);
         drive(4'b0000);
      end
      check("go_hold", 8'b0000_0011);
      drive(4'b0100);
      drive(4'b0000);
`ifdef AUTO_RESTART_EN
      check("go_expire", 8'b0);
`else
      check("go_expire", 8'b0000_0011);
`endif
      drive(4'b1000);
      check("restart_clr", 8'b0010_0000);
      drive(4'b0000);
      do_serve(1'b0, "serve4");
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].in);
         check(tbl[i].name, tbl[i].exp);
      end
      do_serve(1'b1, "serve5");
      for (int k = 2; k <= 9; k++) begin
         drive(4'b0001);
         check("left_point", (k == 9) ? 8'b1000_1010 : 8'b1000_1000);
         drive(4'b0000);
         if (k < 9) do_serve(1'b1, "serve_l");
      end
      drive(4'b1000);
      check("restart2_clr", 8'b0010_0000);
      drive(4'b0000);
      do_serve(1'b0, "serve6");
      rst = 1'b0;
      #1;
      check("async_rst", 8'b0);
      tick();
      check("rst_held", 8'b0);
      rst = 1'b1;
      drive(4'b0000);
      check("after_rst", 8'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
